// File: rtl/clock_prog_divider_if.sv
// Control/status bundle for the programmable clock divider.
// master drives the divisor controls; slave is the divider itself.
interface clock_prog_divider_if #(
  parameter int unsigned CNT_W = 16
);
  logic             enable;
  logic [CNT_W-1:0] div_value;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             pending;
  logic [CNT_W-1:0] active_div;

  modport master (
    output enable,
    output div_value,
    output div_load,
    input  clk_out,
    input  tick,
    input  pending,
    input  active_div
  );

  modport slave (
    input  enable,
    input  div_value,
    input  div_load,
    output clk_out,
    output tick,
    output pending,
    output active_div
  );
endinterface

// File: rtl/clock_prog_divider.sv
// Programmable clock divider with a shadowed divisor that is swapped in only at a period wrap,
// so clk_out never shows a truncated period. All outputs are registered.
module clock_prog_divider #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  clock_prog_divider_if.slave  bus
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_tick;

  logic [CNT_W-1:0] w_load_val;
  logic             w_wrap;
  logic [CNT_W-1:0] w_active_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W:0]   w_half;

  always_comb begin
    w_load_val = (bus.div_value < MinDiv) ? MinDiv : bus.div_value;
    w_wrap     = bus.enable && (r_cnt == (r_active - CNT_W'(1)));

    // A load landing on the wrap cycle bypasses the shadow and applies immediately.
    w_active_d = r_active;
    if (w_wrap) begin
      w_active_d = bus.div_load ? w_load_val : r_shadow;
    end

    w_cnt_d = r_cnt;
    if (bus.enable) begin
      w_cnt_d = w_wrap ? '0 : (r_cnt + CNT_W'(1));
    end

    // Extra bit keeps active_div + 1 from overflowing at the maximum divisor.
    w_half = ({1'b0, w_active_d} + (CNT_W+1)'(1)) >> 1;
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_cnt     <= DefDiv - CNT_W'(1);
      r_active  <= DefDiv;
      r_shadow  <= DefDiv;
      r_pending <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_active <= w_active_d;

      if (bus.div_load) begin
        r_shadow <= w_load_val;
      end

      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (bus.div_load) begin
        r_pending <= 1'b1;
      end

      if (bus.enable) begin
        r_clk_out <= ({1'b0, w_cnt_d} < w_half);
      end
      r_tick <= bus.enable && (w_cnt_d == '0);
    end
  end

  assign bus.clk_out    = r_clk_out;
  assign bus.tick       = r_tick;
  assign bus.pending    = r_pending;
  assign bus.active_div = r_active;

endmodule

// File: tb/tb_clock_prog_divider.sv
// Scoreboard bench for clock_prog_divider: directed per-cycle vectors push hand-computed
// expected outputs; a monitor pops and compares one entry after every rising edge.
module tb_clock_prog_divider;

  localparam int unsigned CNT_W = 16;

  typedef struct {
    int          step;
    logic        clk_out;
    logic        tick;
    logic        pending;
    logic [15:0] active_div;
  } exp_t;

  logic clk_in;
  logic reset;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step_no;

  clock_prog_divider_if #(.CNT_W(CNT_W)) bus ();

  clock_prog_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int step, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, step, got, want);
    end
  endtask

  // Monitor: outputs are registered, so every edge presents a result to compare.
  always @(posedge clk_in) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("clk_out",    e.step, int'(bus.clk_out),    int'(e.clk_out));
      chk("tick",       e.step, int'(bus.tick),       int'(e.tick));
      chk("pending",    e.step, int'(bus.pending),    int'(e.pending));
      chk("active_div", e.step, int'(bus.active_div), int'(e.active_div));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst_n, input logic en, input int dv, input logic ld,
                      input logic e_clk, input logic e_tick, input logic e_pend, input int e_act);
    exp_t e;
    @(negedge clk_in);
    reset         = rst_n;
    bus.enable    = en;
    bus.div_value = 16'(dv);
    bus.div_load  = ld;
    step_no++;
    e.step       = step_no;
    e.clk_out    = e_clk;
    e.tick       = e_tick;
    e.pending    = e_pend;
    e.active_div = 16'(e_act);
    exp_q.push_back(e);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    step_no       = 0;
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.div_value = '0;
    bus.div_load  = 1'b0;

    // Reset, including reset overriding enable and a load.
    step(0, 0, 0, 0,  0, 0, 0, 2);
    step(0, 1, 7, 1,  0, 0, 0, 2);
    step(1, 0, 0, 0,  0, 0, 0, 2);
    // Default divide-by-2: first enabled cycle wraps.
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);
    // Load 5 while frozen: pending, nothing else moves.
    step(1, 0, 5, 1,  0, 0, 1, 2);
    step(1, 1, 0, 0,  1, 1, 0, 5);
    step(1, 1, 0, 0,  1, 0, 0, 5);
    step(1, 1, 0, 0,  1, 0, 0, 5);
    step(1, 1, 0, 0,  0, 0, 0, 5);
    step(1, 1, 0, 0,  0, 0, 0, 5);
    step(1, 1, 0, 0,  1, 1, 0, 5);
    step(1, 1, 0, 0,  1, 0, 0, 5);
    step(1, 1, 0, 0,  1, 0, 0, 5);
    step(1, 1, 0, 0,  0, 0, 0, 5);
    step(1, 1, 0, 0,  0, 0, 0, 5);
    // Load 4 on the wrap cycle: applied at once, pending stays low.
    step(1, 1, 4, 1,  1, 1, 0, 4);
    step(1, 1, 0, 0,  1, 0, 0, 4);
    // Load 6 at cnt=1: current period finishes as 4.
    step(1, 1, 6, 1,  0, 0, 1, 4);
    step(1, 1, 0, 0,  0, 0, 1, 4);
    step(1, 1, 0, 0,  1, 1, 0, 6);
    step(1, 1, 0, 0,  1, 0, 0, 6);
    step(1, 1, 0, 0,  1, 0, 0, 6);
    step(1, 1, 0, 0,  0, 0, 0, 6);
    step(1, 1, 0, 0,  0, 0, 0, 6);
    step(1, 1, 0, 0,  0, 0, 0, 6);
    step(1, 1, 0, 0,  1, 1, 0, 6);
    // Load 0 then 1: both clamp to 2, last one wins.
    step(1, 1, 0, 1,  1, 0, 1, 6);
    step(1, 1, 1, 1,  1, 0, 1, 6);
    step(1, 1, 0, 0,  0, 0, 1, 6);
    step(1, 1, 0, 0,  0, 0, 1, 6);
    step(1, 1, 0, 0,  0, 0, 1, 6);
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);
    // D=4 via wrap-coincident load, then freeze 3 cycles at cnt=2.
    step(1, 1, 4, 1,  1, 1, 0, 4);
    step(1, 1, 0, 0,  1, 0, 0, 4);
    step(1, 1, 0, 0,  0, 0, 0, 4);
    step(1, 0, 0, 0,  0, 0, 0, 4);
    step(1, 0, 0, 0,  0, 0, 0, 4);
    step(1, 0, 0, 0,  0, 0, 0, 4);
    step(1, 1, 0, 0,  0, 0, 0, 4);
    step(1, 1, 0, 0,  1, 1, 0, 4);
    step(1, 1, 0, 0,  1, 0, 0, 4);
    // Mid-period reset with a pending load: the load is discarded.
    step(1, 1, 3, 1,  0, 0, 1, 4);
    step(0, 1, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0,  1, 1, 0, 2);
    step(1, 1, 0, 0,  0, 0, 0, 2);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk_in);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
